// File: rtl/alu_arbiter_8bit.sv
// alu_arbiter_8bit
//   Two-requester, round-robin arbitrated 8-bit ALU. A granted request has
//   its opcode/operands latched in IDLE, is computed in EXEC, and is
//   acknowledged with a one-cycle registered pulse after DONE.
//
// Parameters
//   RR_INIT  requester holding round-robin priority after reset (0 or 1)
// Ports
//   clk                  clock, rising edge
//   rst_n                synchronous active-low reset
//   req0/op0/a0/b0       requester 0: request, opcode[2:0], operands[7:0]
//   req1/op1/a1/b1       requester 1: same meaning
//   ack0, ack1           one-cycle pulse, result belongs to that requester
//   result[7:0]          registered ALU result
//   carry                registered carry / borrow / shift-out
//   zero                 registered result == 0 flag
//   busy                 high whenever the FSM is not IDLE
module alu_arbiter_8bit #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result,
  output logic       carry,
  output logic       zero,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       prio_q,  prio_d;
  logic       gnt_q,   gnt_d;
  logic [2:0] op_q,    op_d;
  logic [7:0] a_q,     a_d;
  logic [7:0] b_q,     b_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       zero_q,  zero_d;
  logic       ack0_q,  ack0_d;
  logic       ack1_q,  ack1_d;

  logic       sel;
  logic [7:0] alu_res;
  logic       alu_carry;

  // Requester to grant: the only one asking, or the priority holder on a tie.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) sel = prio_q;
    else if (req1)    sel = 1'b1;
  end

  // ALU on the latched operands only.
  always_comb begin
    logic [8:0] wide;
    wide      = '0;
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      3'b000: alu_res = a_q & b_q;
      3'b001: alu_res = a_q | b_q;
      3'b010: alu_res = a_q ^ b_q;
      3'b011: alu_res = ~a_q;
      3'b100: begin
        wide      = {1'b0, a_q} + {1'b0, b_q};
        alu_res   = wide[7:0];
        alu_carry = wide[8];
      end
      3'b101: begin
        // Bit 8 of the 9-bit difference is the unsigned borrow (a < b).
        wide      = {1'b0, a_q} - {1'b0, b_q};
        alu_res   = wide[7:0];
        alu_carry = wide[8];
      end
      3'b110: begin
        alu_res   = {a_q[6:0], 1'b0};
        alu_carry = a_q[7];
      end
      default: begin
        alu_res   = {1'b0, a_q[7:1]};
        alu_carry = a_q[0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    gnt_d    = gnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = sel;
          op_d    = sel ? op1 : op0;
          a_d     = sel ? a1  : a0;
          b_d     = sel ? b1  : b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_res;
        carry_d  = alu_carry;
        zero_d   = (alu_res == 8'h00);
        state_d  = DONE;
      end
      DONE: begin
        // Ack is registered, so it is visible in the cycle after DONE.
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
        prio_d  = ~gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      prio_q   <= RR_INIT;
      gnt_q    <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      gnt_q    <= gnt_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter_8bit.md
ALU_ARBITER_8BIT -- requirements
Module: alu_arbiter_8bit

Interface
REQ-001 Parameter: RR_INIT, default 0, requester holding round-robin priority after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low, sampled on rising edge of clk.
REQ-004 req0  input  1  requester 0 operation request; held high until ack0.
REQ-005 op0  input  3  requester 0 opcode.
REQ-006 a0  input  8  requester 0 operand A.
REQ-007 b0  input  8  requester 0 operand B.
REQ-008 req1, op1, a1, b1  input  1/3/8/8  requester 1, same meaning as requester 0.
REQ-009 ack0  output  1  one-cycle pulse: result belongs to requester 0.
REQ-010 ack1  output  1  one-cycle pulse: result belongs to requester 1.
REQ-011 result  output  8  registered ALU result.
REQ-012 carry  output  1  registered carry/borrow/shift-out flag.
REQ-013 zero  output  1  registered flag; 1 when result == 8'h00.
REQ-014 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, DONE; no other states reachable.
REQ-016 IDLE: no request -> stay IDLE; any request -> grant one requester, latch its op/a/b into internal registers, go EXEC.
REQ-017 Arbitration: one requester high -> grant it; both high -> grant requester named by priority register.
REQ-018 EXEC: compute on latched operands, register result/carry/zero, go DONE; inputs changing during EXEC or DONE SHALL NOT affect the operation.
REQ-019 DONE: assert ack of granted requester only, for exactly one cycle; set priority to the non-granted requester; go IDLE.
REQ-020 Latency: req sampled high in IDLE at edge n -> ack high during cycle following edge n+2; throughput one operation per 3 cycles.
REQ-021 Requesters SHALL deassert req on the edge at which ack is sampled high; req still high in IDLE is a new request.
REQ-022 ack0 and ack1 SHALL never be high in the same cycle.
REQ-023 Opcodes: 000 AND, 001 OR, 010 XOR, 011 NOT a, 100 ADD a+b, 101 SUB a-b, 110 SHL a by 1, 111 SHR a by 1 logical.
REQ-024 carry: ADD = bit 8 of 9-bit sum; SUB = 1 when a<b unsigned (borrow); SHL = a[7]; SHR = a[0]; logic ops = 0.
REQ-025 All arithmetic modulo 256; result is low 8 bits.
REQ-026 result, carry, zero SHALL hold value from last completed operation until next EXEC completes.
REQ-027 Request arriving while busy SHALL wait; it is arbitrated at next IDLE cycle.

Reset
REQ-028 rst_n low at a rising edge SHALL force state IDLE, priority = RR_INIT, result = 8'h00, carry = 0, zero = 0, ack0 = ack1 = 0, busy = 0.
REQ-029 Reset during EXEC or DONE SHALL abort the operation with no ack issued; a still-asserted req is served after reset release.
REQ-030 Reset SHALL take precedence over every other transition in the same cycle.

Verification
REQ-031 rst_n low 2 cycles -> result 8'h00, carry 0, zero 0, ack0/ack1 0, busy 0; idle with no req stays so 10 cycles.
REQ-032 req0, op0=000, a0=8'h07, b0=8'h0A -> busy high 2 cycles, ack0 pulse 1 cycle at latency 3, result 8'h02, carry 0, zero 0.
REQ-033 req1, op1=100, a1=8'hFF, b1=8'h01 -> ack1, result 8'h00, carry 1, zero 1; then op1=101, a1=8'h05, b1=8'h09 -> result 8'hFC, carry 1, zero 0.
REQ-034 RR_INIT=0, req0 and req1 raised same cycle (op0=000 8'h01/8'h16, op1=110 a1=8'h81) -> ack0 first with result 8'h00 zero 1, ack1 3 cycles later with result 8'h02 carry 1; repeated contention alternates grants.
REQ-035 req0 op0=111 a0=8'h01; rst_n low one cycle while in EXEC -> no ack0, outputs zeroed; req0 held -> ack0 after release with result 8'h00, carry 1, zero 1.
